// File: rtl/uart_rx_avalon_if.sv
// uart_rx_avalon_if: Avalon-MM register port bundle for the UART receiver
interface uart_rx_avalon_if;
  logic        s_address;
  logic        s_cs;
  logic        s_read;
  logic        s_write;
  logic [3:0]  s_byte_enable;
  logic [31:0] s_write_data;
  logic [31:0] s_read_data;
  modport master (output s_address, s_cs, s_read, s_write, s_byte_enable, s_write_data, input s_read_data);
  modport slave (input s_address, s_cs, s_read, s_write, s_byte_enable, s_write_data, output s_read_data);
endinterface

// File: rtl/uart_rx_avalon.sv
// uart_rx_avalon: UART receiver with byte FIFO and Avalon-MM slave; define UART_RX_PARITY_EN for 8E1 even parity
module uart_rx_avalon #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rxd,
  uart_rx_avalon_if.slave bus,
  output logic irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif
  state_t state, state_d;
  logic rx_meta, rxs, tick, push, set_fe, set_pe, par_bad;
  logic [15:0] cnt, cnt_d;
  logic [2:0] bit_idx, bit_d;
  logic [7:0] shift, shift_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [4:0] cnt5;
  logic [3:0] fill;
  logic [2:0] w1c;
  logic ovr, fe, pe, irq_en, empty, full, rd_acc, st_wr, pop, wr_en, set_ovr;
  logic [7:0] head;
  logic [31:0] rxdata, status;
  logic unused_bits;
  assign tick = cnt == 16'd0;
  assign set_pe = push ? 1'b0 : (state == STOP) & tick & par_bad;
`ifdef UART_RX_PARITY_EN
  logic par_bad_d;
  always_ff @(posedge clk)
    if (rst) par_bad <= 1'b0;
    else par_bad <= par_bad_d;
  always_comb begin
    par_bad_d = par_bad;
    if (state == PARITY && tick) par_bad_d = rxs ^ (^shift);
  end
`else
  assign par_bad = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rx_meta <= 1'b1;
      rxs <= 1'b1;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
    end else begin
      state <= state_d;
      rx_meta <= uart_rxd;
      rxs <= rx_meta;
      cnt <= cnt_d;
      bit_idx <= bit_d;
      shift <= shift_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = tick ? cnt : cnt - 16'd1;
    bit_d = bit_idx;
    shift_d = shift;
    push = 1'b0;
    set_fe = 1'b0;
    case (state)
      IDLE: if (!rxs) begin
        cnt_d = HALF;
        state_d = START;
      end
      START: if (tick) begin
        cnt_d = FULL;
        bit_d = '0;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (tick) begin
        shift_d = {rxs, shift[7:1]};
        cnt_d = FULL;
        bit_d = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_idx == 3'd7) state_d = PARITY;
`else
        if (bit_idx == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        cnt_d = FULL;
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        push = rxs & !par_bad;
        set_fe = !rxs;
        state_d = rxs ? IDLE : BREAK;
      end
      BREAK: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign empty = count == '0;
  assign full = count == CW'(FIFO_DEPTH);
  assign rd_acc = bus.s_cs & bus.s_read;
  assign st_wr = bus.s_cs & bus.s_write & bus.s_address & bus.s_byte_enable[0];
  assign pop = rd_acc & !bus.s_address & bus.s_byte_enable[0] & !empty;
  assign wr_en = push & (!full | pop);
  assign set_ovr = push & full & !pop;
  assign w1c = st_wr ? bus.s_write_data[3:1] : 3'b000;
  assign head = empty ? 8'h00 : mem[rd_ptr];
  assign cnt5 = 5'(count);
  assign fill = cnt5[4] ? 4'hF : cnt5[3:0];
  assign rxdata = {16'h0, !empty, ovr, fe, pe, 4'h0, head};
  assign status = {23'h0, state != IDLE, fill, pe, fe, ovr, irq_en};
  assign unused_bits = ^{bus.s_write_data[31:4], bus.s_byte_enable[3:1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovr <= 1'b0;
      fe <= 1'b0;
      pe <= 1'b0;
      irq_en <= 1'b0;
      irq <= 1'b0;
      bus.s_read_data <= '0;
    end else begin
      if (wr_en) mem[wr_ptr] <= shift;
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(wr_en) - CW'(pop);
      ovr <= set_ovr | (ovr & !w1c[0]);
      fe <= set_fe | (fe & !w1c[1]);
      pe <= set_pe | (pe & !w1c[2]);
      if (st_wr) irq_en <= bus.s_write_data[0];
      if (rd_acc) bus.s_read_data <= bus.s_address ? status : rxdata;
      irq <= irq_en & !empty;
    end
  end
endmodule

// File: tb/tb_uart_rx_avalon.sv
// tb_uart_rx_avalon: scoreboard bench for uart_rx_avalon at 8 clocks per bit, 4-entry FIFO
module tb_uart_rx_avalon;
  typedef struct {logic [31:0] v; string tag;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic irq;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  uart_rx_avalon_if bus();
  uart_rx_avalon #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .uart_rxd(rxd), .bus(bus.slave), .irq(irq));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!rst && bus.s_cs && bus.s_read) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got %h, nothing expected", bus.s_read_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.s_read_data !== e.v) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.tag, bus.s_read_data, e.v);
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic rd(input logic a, input logic [3:0] be, input logic [31:0] v, input string tag);
    exp_t e;
    e.v = v;
    e.tag = tag;
    exp_q.push_back(e);
    bus.s_address = a;
    bus.s_byte_enable = be;
    bus.s_cs = 1'b1;
    bus.s_read = 1'b1;
    @(negedge clk);
    bus.s_cs = 1'b0;
    bus.s_read = 1'b0;
  endtask
  task automatic wr(input logic [31:0] d);
    bus.s_address = 1'b1;
    bus.s_byte_enable = 4'b0001;
    bus.s_write_data = d;
    bus.s_cs = 1'b1;
    bus.s_write = 1'b1;
    @(negedge clk);
    bus.s_cs = 1'b0;
    bus.s_write = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (8) @(negedge clk);
    end
    rxd = stop;
    repeat (8) @(negedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.s_address = 1'b0;
    bus.s_cs = 1'b0;
    bus.s_read = 1'b0;
    bus.s_write = 1'b0;
    bus.s_byte_enable = 4'h0;
    bus.s_write_data = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", bus.s_read_data, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rd(1'b1, 4'h1, 32'h0, "rst_status");
    send(8'h5A, 1'b1);
    repeat (7) @(negedge clk);
    rd(1'b0, 4'b0010, 32'h805A, "peek_5a");
    rd(1'b0, 4'b0001, 32'h805A, "pop_5a");
    rd(1'b0, 4'b0001, 32'h0, "empty_after_pop");
    send(8'h81, 1'b1);
    send(8'h03, 1'b1);
    repeat (4) @(negedge clk);
    chk("irq_off_no_en", {31'h0, irq}, 32'h0);
    rd(1'b1, 4'h1, 32'h20, "status_lvl2");
    wr(32'h1);
    @(negedge clk);
    chk("irq_on", {31'h0, irq}, 32'h1);
    rd(1'b0, 4'b0010, 32'h8081, "peek_81");
    rd(1'b0, 4'b0001, 32'h8081, "pop_81");
    rd(1'b0, 4'b0001, 32'h8003, "pop_03");
    chk("irq_hold", {31'h0, irq}, 32'h1);
    @(negedge clk);
    chk("irq_drop", {31'h0, irq}, 32'h0);
    wr(32'h0);
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b1);
    repeat (4) @(negedge clk);
    rd(1'b1, 4'h1, 32'h42, "status_ovr");
    for (int i = 0; i < 4; i++) rd(1'b0, 4'b0001, 32'hC010 + 32'(i), "pop_ovr");
    rd(1'b1, 4'h1, 32'h2, "status_ovr_empty");
    wr(32'h2);
    rd(1'b1, 4'h1, 32'h0, "ovr_cleared");
    send(8'h33, 1'b0);
    repeat (16) @(negedge clk);
    rd(1'b1, 4'h1, 32'h104, "break_busy");
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    rd(1'b1, 4'h1, 32'h4, "framing_idle");
    send(8'h44, 1'b1);
    repeat (4) @(negedge clk);
    rd(1'b0, 4'b0001, 32'hA044, "after_break");
    wr(32'h4);
    rd(1'b1, 4'h1, 32'h0, "fe_cleared");
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    @(negedge clk);
    rd(1'b1, 4'h1, 32'h100, "glitch_start");
    repeat (10) @(negedge clk);
    rd(1'b1, 4'h1, 32'h0, "glitch_idle");
    rd(1'b0, 4'b0000, 32'h0, "glitch_peek");
    wr(32'h1);
    rd(1'b1, 4'h1, 32'h1, "irq_en_set");
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rxd = (i == 4);
      repeat (8) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midframe_rst_rdata", bus.s_read_data, 32'h0);
    chk("midframe_rst_irq", {31'h0, irq}, 32'h0);
    repeat (30) @(negedge clk);
    rd(1'b1, 4'h1, 32'h0, "post_reset_status");
    rd(1'b0, 4'b0000, 32'h0, "post_reset_peek");
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
